cmp_pipe: RTL
=============

// Module: cmp_pipe
// PURPOSE
//   Parametrised, pipelined branch-condition comparator with valid/ready handshake.
//   Evaluates EQ/NE/LT/LTU/GE/GEU on two WIDTH-bit operands over STAGES register stages.
//   Carries a TAG for result matching and supports a flush for mispredict/kill.
//   Sits between the ID/EX operand path and the branch-resolve logic of the pipelined core.
// PARAMETERS
//   WIDTH   32  operand width, even, >= 2
//   STAGES  2   pipeline depth. 1 = full compare in one stage; 2 = half-split compare then merge.
//               Any other value is a compile-time error.
//   TAG_W   4   width of the pass-through tag
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   flush      in   1       synchronous kill of all in-flight ops
//   in_valid   in   1       input op valid
//   in_ready   out  1       block can accept an op this cycle
//   in_a       in   WIDTH   operand a
//   in_b       in   WIDTH   operand b
//   in_ctrl    in   3       001 EQ, 010 NE, 011 LT, 100 LTU, 101 GE, 110 GEU
//   in_tag     in   TAG_W   opaque tag, returned with the result
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts the result
//   out_c      out  1       condition true
//   out_ill    out  1       in_ctrl was 000 or 111; out_c forced to 0
//   out_tag    out  TAG_W   tag of this result
// BEHAVIOUR
//   - Reset (rst_n low, async): all stage valid bits 0, all data/ctrl/tag regs 0.
//     Outputs are then out_valid=0, out_c=0, out_ill=0, out_tag=0.
//     in_ready=1 from the first edge after release.
//   - Transfers: input on in_valid&in_ready at a rising edge; output on out_valid&out_ready.
//   - Latency: an op accepted at edge N presents out_valid after edge N+STAGES-1,
//     i.e. STAGES register stages.
//   - Throughput is 1 op/cycle while out_ready=1.
//   - Stage k advances when it is empty or stage k+1 advances; the last stage
//     advances when out_ready=1 or it is empty.
//   - in_ready = ~s1_valid | s1_advance (combinational, no bubble under continuous flow).
//   - Backpressure: while out_valid=1 and out_ready=0, out_* hold stable.
//     No op is dropped or duplicated. Once all stages are full, in_ready=0.
//   - Arithmetic: LTU = unsigned a<b.
//     LT = (a[W-1]&~b[W-1]) | (~(a[W-1]^b[W-1]) & a<b unsigned).
//     NE=~EQ, GE=~LT, GEU=~LTU.
//   - STAGES=2 split:
//     stage 1 registers hi/lo half eq and hi/lo half ltu, plus both sign bits, ctrl and tag.
//     stage 2: EQ=eq_hi&eq_lo; LTU=ltu_hi|(eq_hi&ltu_lo); LT is derived from LTU and the signs.
//     stage 2 then registers c/ill/tag.
//   - STAGES=1: full compare in one stage; the result register drives out_*.
//   - Illegal ctrl (000, 111): out_c=0, out_ill=1. The op still flows and must be consumed.
//   - flush=1 at an edge:
//     - all stage valid bits clear to 0;
//     - an input presented in the same cycle is discarded, even if in_ready=1;
//     - an output handshaking in that cycle counts as consumed;
//     - out_valid=0 on the following cycle.
//   - Flush does not clear data regs; only valids.
//   - Reset mid-operation: all in-flight ops are lost; no partial result appears after release.
//   - Result width is WIDTH-independent; no wrap or overflow paths exist.
// TESTING
//   1 WIDTH=32: a=FFFFFFFF, b=00000001
//     LT  -> c=1; LTU -> c=0; GE -> c=0; GEU -> c=1; EQ -> c=0; NE -> c=1.
//   2 STAGES=2, out_ready=1: four ops tags 1..4, back-to-back
//     -> out_valid on 4 consecutive cycles, starting 2 edges after the first accept.
//     Tags come out in order 1,2,3,4.
//   3 out_ready=0 for 5 cycles while in_valid=1
//     -> in_ready falls after STAGES accepts; out_* stable.
//     On release all ops appear once, in order.
//   4 flush with 2 ops in flight and a 3rd presented
//     -> out_valid=0 next cycle; none of the 3 ever appears.
//     An op sent the cycle after returns normally.
//   5 in_ctrl=111, a=b=0 -> out_c=0, out_ill=1, consumed normally.
//     Then in_ctrl=001 -> out_c=1, out_ill=0.
//   6 WIDTH=8 and WIDTH=32, STAGES=1/2: 10k random ops, random valid/ready/flush
//     -> match reference model.
//     Assert rst_n low mid-stream -> out_valid=0 at once, no stale result afterwards.

Source files
------------

// File: rtl/cmp_pipe.sv
// rtl/cmp_pipe.sv - pipelined branch-condition comparator with valid/ready handshake
module cmp_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_ctrl,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_c,
   output logic             out_ill,
   output logic [TAG_W-1:0] out_tag
);

   // Returns {ill, c}; signed less-than is rebuilt from the unsigned result and the two signs.
   function automatic logic [1:0] resolve(input logic [2:0] ctrl, input logic eq, input logic ltu,
                                          input logic sign_a, input logic sign_b);
      logic lt;
      logic c;
      logic ill;
      lt  = (sign_a & ~sign_b) | (~(sign_a ^ sign_b) & ltu);
      c   = 1'b0;
      ill = 1'b0;
      case (ctrl)
         3'b001:  c = eq;
         3'b010:  c = ~eq;
         3'b011:  c = lt;
         3'b100:  c = ltu;
         3'b101:  c = ~lt;
         3'b110:  c = ~ltu;
         default: ill = 1'b1;
      endcase
      return {ill, c};
   endfunction

   logic             res_valid;
   logic             res_c;
   logic             res_ill;
   logic [TAG_W-1:0] res_tag;
   logic             res_advance;
   logic             nxt_valid;
   logic [1:0]       nxt_flags;
   logic [TAG_W-1:0] nxt_tag;

   assign res_advance = ~res_valid | out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_c     <= 1'b0;
         res_ill   <= 1'b0;
         res_tag   <= '0;
      end else if (flush) begin
         res_valid <= 1'b0;
      end else if (res_advance) begin
         res_valid <= nxt_valid;
         if (nxt_valid) begin
            {res_ill, res_c} <= nxt_flags;
            res_tag          <= nxt_tag;
         end
      end
   end

   assign out_valid = res_valid;
   assign out_c     = res_c;
   assign out_ill   = res_ill;
   assign out_tag   = res_tag;

   generate
      if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
         $error("cmp_pipe: WIDTH must be even and >= 2");
      end

      if (STAGES == 1) begin : g_one
         assign in_ready  = res_advance;
         assign nxt_valid = in_valid;
         assign nxt_flags = resolve(in_ctrl, in_a == in_b, in_a < in_b,
                                    in_a[WIDTH-1], in_b[WIDTH-1]);
         assign nxt_tag   = in_tag;
      end else if (STAGES == 2) begin : g_two
         localparam int HW = WIDTH / 2;

         logic             s1_valid;
         logic             s1_eq_hi;
         logic             s1_eq_lo;
         logic             s1_ltu_hi;
         logic             s1_ltu_lo;
         logic             s1_sign_a;
         logic             s1_sign_b;
         logic [2:0]       s1_ctrl;
         logic [TAG_W-1:0] s1_tag;
         logic             s1_advance;

         assign s1_advance = ~s1_valid | res_advance;
         assign in_ready   = s1_advance;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_valid  <= 1'b0;
               s1_eq_hi  <= 1'b0;
               s1_eq_lo  <= 1'b0;
               s1_ltu_hi <= 1'b0;
               s1_ltu_lo <= 1'b0;
               s1_sign_a <= 1'b0;
               s1_sign_b <= 1'b0;
               s1_ctrl   <= '0;
               s1_tag    <= '0;
            end else if (flush) begin
               s1_valid <= 1'b0;
            end else if (s1_advance) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_eq_hi  <= in_a[WIDTH-1:HW] == in_b[WIDTH-1:HW];
                  s1_eq_lo  <= in_a[HW-1:0] == in_b[HW-1:0];
                  s1_ltu_hi <= in_a[WIDTH-1:HW] < in_b[WIDTH-1:HW];
                  s1_ltu_lo <= in_a[HW-1:0] < in_b[HW-1:0];
                  s1_sign_a <= in_a[WIDTH-1];
                  s1_sign_b <= in_b[WIDTH-1];
                  s1_ctrl   <= in_ctrl;
                  s1_tag    <= in_tag;
               end
            end
         end

         // Merge the half compares: the high half decides unless it is equal.
         assign nxt_valid = s1_valid;
         assign nxt_flags = resolve(s1_ctrl, s1_eq_hi & s1_eq_lo,
                                    s1_ltu_hi | (s1_eq_hi & s1_ltu_lo),
                                    s1_sign_a, s1_sign_b);
         assign nxt_tag   = s1_tag;
      end else begin : g_bad_stages
         $error("cmp_pipe: STAGES must be 1 or 2");
         assign in_ready  = 1'b0;
         assign nxt_valid = 1'b0;
         assign nxt_flags = 2'b00;
         assign nxt_tag   = '0;
      end
   endgenerate

endmodule
